// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl
// Fetch-side owner of the architectural PC. Issues one instruction-memory
// read at a time and presents {instr, pc, pc+4} to the IF/ID register through
// a valid/ready handshake. Branch/jump redirects resolved in D are deferred
// by one instruction so that the fetch already in flight or held becomes the
// MIPS delay slot.

module ifu_fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc4,
    output logic              if_adel
);

    localparam logic [ADDR_W-1:0] PC_STEP = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pend_target;
    logic              pend_valid;
    logic [ADDR_W-1:0] next_addr;
    logic              handoff;

    // The request address is the registered fetch PC, so it stays stable
    // for as long as the request waits for a grant.
    assign imem_addr = fetch_pc;
    assign handoff   = (state == HOLD) && if_valid && if_ready;

    // Next fetch address: a same-cycle redirect wins, then a pending one, else sequential.
    always_comb begin
        next_addr = if_pc + PC_STEP;
        if (redirect_valid) begin
            next_addr = redirect_target;
        end else if (pend_valid) begin
            next_addr = pend_target;
        end
    end

    // Fetch FSM with registered memory request, output register and pending redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            imem_req    <= 1'b0;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= RESET_PC;
            if_pc4      <= RESET_PC + PC_STEP;
            if_adel     <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pend_valid  <= 1'b1;
                pend_target <= redirect_target;
            end

            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= (fetch_pc[1:0] == 2'b00);
                end

                REQ: begin
                    if (fetch_pc[1:0] != 2'b00) begin
                        state    <= HOLD;
                        imem_req <= 1'b0;
                        if_valid <= 1'b1;
                        if_instr <= '0;
                        if_pc    <= fetch_pc;
                        if_pc4   <= fetch_pc + PC_STEP;
                        if_adel  <= 1'b1;
                    end else if (imem_gnt) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                    end
                end

                WAIT: begin
                    if (imem_rvalid) begin
                        state    <= HOLD;
                        if_valid <= 1'b1;
                        if_instr <= imem_rdata;
                        if_pc    <= fetch_pc;
                        if_pc4   <= fetch_pc + PC_STEP;
                        if_adel  <= 1'b0;
                    end
                end

                HOLD: begin
                    if (handoff) begin
                        state      <= REQ;
                        if_valid   <= 1'b0;
                        if_adel    <= 1'b0;
                        fetch_pc   <= next_addr;
                        pend_valid <= 1'b0;
                        imem_req   <= (next_addr[1:0] == 2'b00);
                    end
                end

                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Fetch-side consumer of next-PC values. Owns the architectural PC register and issues instruction-memory reads through a request/response handshake.
- Accepts branch/jump redirects resolved in D and honours the MIPS single delay slot.
- Delivers {instr, pc, pc+4} to the IF/ID register with a valid/ready handshake; sits between the next-PC calculator and the D-stage register.

Parameters:
- RESET_PC, 32'h0000_3000, address of the first fetch after reset.
- ADDR_W, 32, PC/address width; fixed at 32 for this core.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request valid.
- imem_addr  out  32  word-aligned read address.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; at most one outstanding read.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  D-stage branch taken or jump resolved this cycle.
- redirect_target  in  32  next_PC from the next-PC calculator.
- if_valid  out  1  IF output holds a fetched instruction.
- if_ready  in  1  IF/ID register accepts this cycle (hazard-unit stall = !if_ready).
- if_instr  out  32  fetched instruction.
- if_pc  out  32  address of if_instr.
- if_pc4  out  32  if_pc + 4.
- if_adel  out  1  fetch address misaligned (target[1:0] != 0).

Behaviour:
- Reset (reset low, async):
  - State = IDLE; fetch_pc = RESET_PC; pending redirect cleared.
  - imem_req = 0, if_valid = 0, if_instr = 0, if_pc = RESET_PC, if_pc4 = RESET_PC + 4, if_adel = 0.
  - Reset asserted mid-transaction abandons the outstanding read; any later rvalid is ignored until a new request is granted.
- States:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req = 1, imem_addr = fetch_pc. On imem_gnt, go to WAIT.
  - WAIT: imem_req = 0. On imem_rvalid, capture rdata/pc into the output register, set if_valid = 1, go to HOLD.
  - HOLD: output stable while !if_ready. On if_valid && if_ready, drop if_valid; same cycle set fetch_pc = selected next address, go to REQ.
- Next-address select:
  - Pending redirect present: redirect target, then clear pending.
  - Otherwise: fetched pc + 4 (32-bit wrap; 32'hFFFF_FFFC + 4 = 0).
- Delay slot:
  - A redirect seen in any state is latched into pending; it is not applied to the fetch already in flight or held.
  - The in-flight or held instruction is the delay slot. The address after the delay slot is the target.
  - Redirect in the same cycle as the HOLD hand-off is used directly, bypassing the pending register.
  - A second redirect before the pending one is consumed overwrites it (latest wins).
- Misaligned target:
  - No memory request is issued. The FSM goes REQ→HOLD directly.
  - Outputs: if_instr = 0 (nop), if_pc = target, if_adel = 1, if_valid = 1.
  - if_adel clears on the next hand-off.
- Throughput: at most one instruction per 3 cycles with zero-wait memory (REQ, WAIT, HOLD). Back-to-back pipelining is not required.
- imem_req stays asserted with a stable imem_addr until granted. The request is never withdrawn except by reset.

Test Plan:
- Reset release, zero-wait memory (gnt and rvalid asserted the cycle after req), if_ready = 1:
  - First request address is 32'h3000.
  - if_pc sequence is 3000, 3004, 3008.
  - if_pc4 = if_pc + 4 throughout.
- Stall: hold if_ready = 0 for 5 cycles with an instruction held.
  - if_valid, if_instr and if_pc stay stable.
  - No new imem_req is issued.
  - On release, the next request is if_pc + 4.
- Redirect with delay slot:
  - Stimulus: redirect_target = 32'h3100 while the instruction at 3008 is in WAIT.
  - Delivered if_pc order: 3008 (delay slot), then 3100, then 3104.
- Redirect coincident with hand-off, and double redirect:
  - Redirect on the same cycle as the hand-off: it takes effect on the very next request.
  - Two redirects (3200 then 3300) before consumption: the next fetch is 3300.
- Misaligned target 32'h3102:
  - No imem_req is issued.
  - Outputs: if_valid = 1, if_adel = 1, if_instr = 0, if_pc = 3102.
- Reset asserted asynchronously during WAIT, then rvalid pulses:
  - Outputs return to reset values immediately.
  - The stale rvalid is ignored.
  - Fetch restarts at 32'h3000.
